multi_digit_disp: RTL



---
 rtl/multi_digit_disp.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/multi_digit_disp.sv
// multi_digit_disp
//   Time-multiplexed hex display driver for N_DIGITS seven-segment digits.
//   A prescaler divides the clock into digit slots. Each slot opens with
//   DEAD_CYC clocks where every digit enable is off, which suppresses
//   ghosting. A loaded value is held pending and only becomes visible at
//   a frame boundary, so a frame never shows a mix of old and new digits.
//
// Ports
//   i_Clk          main clock
//   i_Rst_n        asynchronous active-low reset
//   i_Value        value to show, nibble k drives digit k (digit 0 = LSD)
//   i_Load         one-cycle strobe capturing i_Value into the pending reg
//   i_Lz_En        leading-zero blanking enable
//   o_Segments     segments {A,B,C,D,E,F,G}, polarity set by ACTIVE_LOW
//   o_Digit_En     one-hot digit enable (or all off), polarity by ACTIVE_LOW
//   o_Frame_Start  one-cycle pulse as a new frame begins at digit 0
module multi_digit_disp #(
  parameter int unsigned N_DIGITS    = 2,
  parameter int unsigned REFRESH_DIV = 25000,
  parameter int unsigned DEAD_CYC    = 2,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic [4*N_DIGITS-1:0]   i_Value,
  input  logic                    i_Load,
  input  logic                    i_Lz_En,
  output logic [6:0]              o_Segments,
  output logic [N_DIGITS-1:0]     o_Digit_En,
  output logic                    o_Frame_Start
);

  localparam int unsigned P_W   = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [P_W-1:0]      P_LAST   = P_W'(REFRESH_DIV - 1);
  localparam logic [P_W-1:0]      P_DEAD   = P_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_OFF  = {7{ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] DIG_OFF  = {N_DIGITS{ACTIVE_LOW}};

  logic [P_W-1:0]        p_q, p_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [4*N_DIGITS-1:0] disp_q, disp_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   dig_q, dig_d;
  logic                  fs_q, fs_d;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            nib;
  logic                  blank_sel;
  logic [N_DIGITS-1:0]   blank;
  logic                  zero_above;
  logic [6:0]            seg_raw;
  logic [N_DIGITS-1:0]   dig_raw;

  // Prescaler, digit index and value pipeline
  always_comb begin
    tick     = (p_q == P_LAST);
    wrap     = tick && (idx_q == IDX_LAST);
    p_d      = tick ? '0 : p_q + 1'b1;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    disp_d   = disp_q;
    // Frame-wrap transfer is evaluated first so a coincident load re-arms
    // pend_v with the new value while disp takes the old pending one.
    if (wrap && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end
    if (i_Load) begin
      pend_d   = i_Value;
      pend_v_d = 1'b1;
    end
  end

  // Digit selection and leading-zero mask
  always_comb begin
    nib        = '0;
    blank_sel  = 1'b0;
    dig_raw    = '0;
    blank      = '0;
    zero_above = 1'b1;
    // Walk from the most significant digit down: digit k blanks only if it
    // and every digit above it are zero. Digit 0 is never blanked.
    for (int unsigned k = N_DIGITS; k > 1; k--) begin
      zero_above   = zero_above & (disp_q[4*(k-1) +: 4] == 4'h0);
      blank[k-1]   = zero_above;
    end
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib        = disp_q[4*k +: 4];
        blank_sel  = blank[k];
        dig_raw[k] = 1'b1;
      end
    end
    if (p_q < P_DEAD) begin
      dig_raw = '0;
    end
  end

  // Hex to seven-segment, active-high {A,B,C,D,E,F,G}
  always_comb begin
    unique case (nib)
      4'h0: seg_raw = 7'h7E;
      4'h1: seg_raw = 7'h30;
      4'h2: seg_raw = 7'h6D;
      4'h3: seg_raw = 7'h79;
      4'h4: seg_raw = 7'h33;
      4'h5: seg_raw = 7'h5B;
      4'h6: seg_raw = 7'h5F;
      4'h7: seg_raw = 7'h70;
      4'h8: seg_raw = 7'h7F;
      4'h9: seg_raw = 7'h7B;
      4'hA: seg_raw = 7'h77;
      4'hB: seg_raw = 7'h1F;
      4'hC: seg_raw = 7'h4E;
      4'hD: seg_raw = 7'h3D;
      4'hE: seg_raw = 7'h4F;
      default: seg_raw = 7'h47;
    endcase
    if (i_Lz_En && blank_sel) begin
      seg_raw = 7'h00;
    end
    seg_d = ACTIVE_LOW ? ~seg_raw : seg_raw;
    dig_d = ACTIVE_LOW ? ~dig_raw : dig_raw;
    fs_d  = wrap;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      p_q      <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      disp_q   <= '0;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
      fs_q     <= 1'b0;
    end else begin
      p_q      <= p_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      disp_q   <= disp_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      fs_q     <= fs_d;
    end
  end

  assign o_Segments    = seg_q;
  assign o_Digit_En    = dig_q;
  assign o_Frame_Start = fs_q;

endmodule
